// File: rtl/instr_loader.sv
// Instruction loader: parses a byte stream (count header, big-endian data words,
// XOR checksum) and writes each assembled word into instruction memory.
module instr_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t      state_reg, state_next;

    // Word count N from the header, MSB byte first.
    logic [15:0] count_reg, count_next;
    // Index of the word currently being assembled.
    logic [15:0] word_idx_reg, word_idx_next;
    // Position of the next data byte within its word (0 = MSB).
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    // Partially assembled word; lanes fill from bits [31:24] downwards.
    logic [31:0] word_reg, word_next;
    // Running XOR of all data bytes.
    logic [7:0]  csum_reg, csum_next;

    logic        mem_we_reg, mem_we_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;

    logic        xfer;
    logic        start_accept;
    logic        last_byte_of_word;
    logic        last_word;
    logic [15:0] hdr_count;
    logic [31:0] lane_word;

    // A byte moves only when both sides agree in the same cycle.
    assign xfer              = byte_valid && byte_ready;
    // Start is honoured only when no load is running.
    assign start_accept      = (state_reg == IDLE) && start;
    assign last_byte_of_word = (byte_cnt_reg == 2'd3);
    // word_idx never exceeds N-1 while in DATA, so the +1 cannot overflow.
    assign last_word         = ((word_idx_reg + 16'd1) == count_reg);
    // Full word count as it will be once the second header byte lands.
    assign hdr_count         = {count_reg[15:8], byte_in};

    // Big-endian lane steering: lane gi (bits gi*8+7:gi*8) takes byte number 3-gi.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE_SLOT = 2'(3 - gi);
            assign lane_word[gi*8 +: 8] = (byte_cnt_reg == LANE_SLOT) ? byte_in
                                                                      : word_reg[gi*8 +: 8];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic plus the state-decoded handshake and busy outputs.
    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = HDR0;
                end
            end
            HDR0: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    state_next = HDR1;
                end
            end
            HDR1: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    // An empty program goes straight to its checksum byte.
                    state_next = (hdr_count == 16'd0) ? CSUM : DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (xfer && last_byte_of_word && last_word) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Datapath next-state: header capture, word assembly, checksum, write strobe, status.
    always_comb begin
        count_next     = count_reg;
        word_idx_next  = word_idx_reg;
        byte_cnt_next  = byte_cnt_reg;
        word_next      = word_reg;
        csum_next      = csum_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        done_next      = done_reg;
        error_next     = error_reg;

        if (start_accept) begin
            done_next     = 1'b0;
            error_next    = 1'b0;
            word_idx_next = 16'd0;
            csum_next     = 8'h00;
            byte_cnt_next = 2'd0;
        end

        case (state_reg)
            HDR0: begin
                if (xfer) begin
                    count_next[15:8] = byte_in;
                end
            end
            HDR1: begin
                if (xfer) begin
                    count_next[7:0] = byte_in;
                end
            end
            DATA: begin
                if (xfer) begin
                    word_next     = lane_word;
                    csum_next     = csum_reg ^ byte_in;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (last_byte_of_word) begin
                        // Address wraps naturally through 16-bit arithmetic.
                        mem_we_next    = 1'b1;
                        mem_wdata_next = lane_word;
                        mem_addr_next  = BASE_ADDR + word_idx_reg;
                        word_idx_next  = word_idx_reg + 16'd1;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    // Status becomes visible in FIN and stays until the next load.
                    done_next  = 1'b1;
                    error_next = (byte_in != csum_reg);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset drops any partial word and the write strobe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg     <= 16'd0;
            word_idx_reg  <= 16'd0;
            byte_cnt_reg  <= 2'd0;
            word_reg      <= 32'd0;
            csum_reg      <= 8'h00;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= 32'd0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            count_reg     <= count_next;
            word_idx_reg  <= word_idx_next;
            byte_cnt_reg  <= byte_cnt_next;
            word_reg      <= word_next;
            csum_reg      <= csum_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign done      = done_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: two instances (base 0x0000 and 0xFFFF)
// share one stimulus stream; monitors pop expected writes and load status.
module tb_instr_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        byte_ready_a, mem_we_a, busy_a, done_a, error_a;
    logic [15:0] mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic        byte_ready_b, mem_we_b, busy_b, done_b, error_b;
    logic [15:0] mem_addr_b;
    logic [31:0] mem_wdata_b;

    wr_t  exp_a[$];
    wr_t  exp_b[$];
    logic exp_err[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_loader #(.BASE_ADDR(16'h0000)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready_a),
        .mem_we     (mem_we_a),
        .mem_addr   (mem_addr_a),
        .mem_wdata  (mem_wdata_a),
        .busy       (busy_a),
        .done       (done_a),
        .error      (error_a)
    );

    instr_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready_b),
        .mem_we     (mem_we_b),
        .mem_addr   (mem_addr_b),
        .mem_wdata  (mem_wdata_b),
        .busy       (busy_b),
        .done       (done_b),
        .error      (error_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Write monitor for the base-0x0000 instance.
    always @(negedge clk) begin
        if (mem_we_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected write a: addr %h data %h, expected no write", mem_addr_a, mem_wdata_a);
            end else begin
                wr_t e;
                e = exp_a.pop_front();
                check("write a addr", {16'h0, mem_addr_a}, {16'h0, e.addr});
                check("write a data", mem_wdata_a, e.data);
            end
        end
    end

    // Write monitor for the base-0xFFFF instance.
    always @(negedge clk) begin
        if (mem_we_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected write b: addr %h data %h, expected no write", mem_addr_b, mem_wdata_b);
            end else begin
                wr_t e;
                e = exp_b.pop_front();
                check("write b addr", {16'h0, mem_addr_b}, {16'h0, e.addr});
                check("write b data", mem_wdata_b, e.data);
            end
        end
    end

    // Status monitor: on each rising done, compare error against the expected outcome.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done_a === 1'b1 && done_prev === 1'b0) begin
            if (exp_err.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected done: error=%b, expected no completion", error_a);
            end else begin
                logic e;
                e = exp_err.pop_front();
                check("status error a", {31'h0, error_a}, {31'h0, e});
                check("status error b", {31'h0, error_b}, {31'h0, e});
                check("busy in FIN", {31'h0, busy_a}, 32'd1);
            end
        end
        done_prev <= done_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int t;
        byte_valid = 1'b0;
        repeat (gaps) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        t = 0;
        while (byte_ready_a !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake timeout: byte_ready=%b, expected 1", byte_ready_a);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input byte_q_t s, input int max_gap);
        foreach (s[i]) begin
            send_byte(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_a !== 1'b0 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle timeout: busy=%b, expected 0", busy_a);
        end
        tick();
    endtask

    task automatic expect_write(input logic [15:0] addr_a, input logic [15:0] addr_b,
                                input logic [31:0] data);
        exp_a.push_back('{addr: addr_a, data: data});
        exp_b.push_back('{addr: addr_b, data: data});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        byte_q_t s;
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) tick();

        // Reset state.
        check("reset byte_ready", {31'h0, byte_ready_a}, 32'd0);
        check("reset mem_we", {31'h0, mem_we_a}, 32'd0);
        check("reset mem_addr a", {16'h0, mem_addr_a}, 32'h0000);
        check("reset mem_addr b", {16'h0, mem_addr_b}, 32'hFFFF);
        check("reset mem_wdata", mem_wdata_a, 32'h0);
        check("reset busy", {31'h0, busy_a}, 32'd0);
        check("reset done", {31'h0, done_a}, 32'd0);
        check("reset error", {31'h0, error_a}, 32'd0);
        rst = 1'b0;
        tick();

        // Single word, good checksum (DE^AD^BE^EF = 22).
        expect_write(16'h0000, 16'hFFFF, 32'hDEADBEEF);
        exp_err.push_back(1'b0);
        pulse_start();
        check("busy after start", {31'h0, busy_a}, 32'd1);
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_stream(s, 0);
        wait_idle();
        repeat (3) tick();
        check("done sticky", {31'h0, done_a}, 32'd1);

        // Two words, wrong checksum (correct is 88, send 00); base 0xFFFF wraps to 0x0000.
        expect_write(16'h0000, 16'hFFFF, 32'h11223344);
        expect_write(16'h0001, 16'h0000, 32'h55667788);
        exp_err.push_back(1'b1);
        pulse_start();
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        send_stream(s, 0);
        wait_idle();
        repeat (3) tick();
        check("error sticky", {31'h0, error_a}, 32'd1);

        // Empty program, good and bad checksum.
        exp_err.push_back(1'b0);
        pulse_start();
        check("done cleared by start", {31'h0, done_a}, 32'd0);
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 0);
        wait_idle();
        exp_err.push_back(1'b1);
        pulse_start();
        s = '{8'h00, 8'h00, 8'h01};
        send_stream(s, 0);
        wait_idle();

        // Same two-word program with random gaps and a start pulse inside DATA.
        expect_write(16'h0000, 16'hFFFF, 32'h11223344);
        expect_write(16'h0001, 16'h0000, 32'h55667788);
        exp_err.push_back(1'b0);
        pulse_start();
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        send_stream(s, 3);
        pulse_start();
        s = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_stream(s, 3);
        wait_idle();

        // Reset after two data bytes: outputs drop immediately, no write follows.
        pulse_start();
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD};
        send_stream(s, 0);
        rst = 1'b1;
        #1;
        check("midrst byte_ready", {31'h0, byte_ready_a}, 32'd0);
        check("midrst busy", {31'h0, busy_a}, 32'd0);
        check("midrst mem_we", {31'h0, mem_we_a}, 32'd0);
        check("midrst mem_addr a", {16'h0, mem_addr_a}, 32'h0000);
        check("midrst mem_addr b", {16'h0, mem_addr_b}, 32'hFFFF);
        check("midrst mem_wdata", mem_wdata_a, 32'h0);
        check("midrst done", {31'h0, done_a}, 32'd0);
        check("midrst error", {31'h0, error_a}, 32'd0);
        tick();
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'hBE;
        tick();
        byte_in    = 8'hEF;
        tick();
        byte_in    = 8'h22;
        tick();
        byte_valid = 1'b0;
        repeat (3) tick();
        check("post-rst busy", {31'h0, busy_a}, 32'd0);
        check("post-rst done", {31'h0, done_a}, 32'd0);

        // Fresh load after reset works normally.
        expect_write(16'h0000, 16'hFFFF, 32'hDEADBEEF);
        exp_err.push_back(1'b0);
        pulse_start();
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_stream(s, 1);
        wait_idle();
        repeat (5) tick();

        check("pending writes a", exp_a.size(), 32'd0);
        check("pending writes b", exp_b.size(), 32'd0);
        check("pending status", exp_err.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000: word address of the first instruction written.
REQ-002 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: one-cycle pulse arming a new load.
REQ-005 SHALL have port byte_in, input, 8: incoming program stream byte.
REQ-006 SHALL have port byte_valid, input, 1: byte_in holds a valid byte.
REQ-007 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we, output, 1: one-cycle write strobe to the instruction memory write port.
REQ-009 SHALL have port mem_addr, output, 16: word address for mem_we.
REQ-010 SHALL have port mem_wdata, output, 32: instruction word for mem_we.
REQ-011 SHALL have port busy, output, 1: load in progress.
REQ-012 SHALL have port done, output, 1: load finished, sticky until next accepted start.
REQ-013 SHALL have port error, output, 1: checksum mismatch on the last load, sticky until next accepted start.

Function
REQ-014 SHALL transfer a byte only in a cycle where byte_valid and byte_ready are both 1.
REQ-015 SHALL parse the stream as: 2-byte word count N (MSB first), then 4*N data bytes, then 1 checksum byte.
REQ-016 SHALL implement states IDLE, HDR0, HDR1, DATA, CSUM, FIN.
REQ-017 SHALL transition IDLE->HDR0 on start; HDR0->HDR1 and HDR1->DATA on byte transfer; HDR1->CSUM instead when N==0.
REQ-018 SHALL transition DATA->CSUM on transfer of the 4th byte of word N-1, and CSUM->FIN on transfer of the checksum byte.
REQ-019 SHALL transition FIN->IDLE unconditionally after one cycle.
REQ-020 SHALL drive byte_ready=1 exactly in HDR0, HDR1, DATA, CSUM.
REQ-021 SHALL assemble each word big-endian: first data byte -> mem_wdata[31:24], fourth -> [7:0].
REQ-022 SHALL assert mem_we for exactly one cycle, the cycle after the 4th byte of a word transfers, with mem_wdata and mem_addr valid in that cycle.
REQ-023 SHALL use mem_addr = (BASE_ADDR + word index) mod 2^16; index 0 for first word; addresses wrap from 16'hFFFF to 16'h0000.
REQ-024 SHALL hold mem_addr and mem_wdata stable when mem_we=0.
REQ-025 SHALL compute the checksum as XOR of all 4*N data bytes (header excluded), initial value 8'h00.
REQ-026 SHALL, in FIN, set done=1 and set error=1 iff received checksum byte differs from computed value.
REQ-027 SHALL drive busy=1 in HDR0, HDR1, DATA, CSUM, FIN; 0 in IDLE.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL, on start accepted in IDLE, clear done, error, word index, checksum and byte counter in the same edge.
REQ-030 SHALL, in any stall cycle (byte_valid=0), hold all state, counters and partial word.

Reset
REQ-031 SHALL on rst force state IDLE, byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, counters and checksum 0.
REQ-032 SHALL on rst mid-load discard the partial word and issue no further mem_we until a new start.

Verification
REQ-033 SHALL cover: start, stream 00 01 DE AD BE EF 22 -> single mem_we, addr 0x0000, wdata 0xDEADBEEF, done=1, error=0.
REQ-034 SHALL cover: start, stream 00 02, 8 data bytes, wrong checksum -> two mem_we at addr 0,1; done=1, error=1.
REQ-035 SHALL cover: start, stream 00 00 00 -> no mem_we, done=1, error=0; stream 00 00 01 -> error=1.
REQ-036 SHALL cover: BASE_ADDR=16'hFFFF, N=2 -> mem_addr 0xFFFF then 0x0000.
REQ-037 SHALL cover: random byte_valid gaps and a start pulse during DATA -> identical writes to gap-free run, start ignored.
REQ-038 SHALL cover: rst asserted after 2 data bytes -> all outputs at reset values immediately, no mem_we afterward.
